fnd_scan_ctrl: RTL and testbench
================================

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 SHALL have parameter P_SLOT_CYC, default 100000, meaning clocks per digit slot (1 kHz slot rate at 100 MHz); legal range is 2 or more.
REQ-002 SHALL have parameter P_BLANK_CYC, default 16, meaning dead-time clocks at the start of each slot; legal range is 1 to P_SLOT_CYC-1.
REQ-003 SHALL have one clock and one synchronous active-low reset:
- i_clk  in  1  rising-edge clock.
- i_reset_n  in  1  synchronous active-low reset.
REQ-004 SHALL have these remaining ports:
- i_bcd  in  16  four BCD digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- i_load  in  1  single-cycle strobe requesting that i_bcd be displayed.
- o_load_ack  out  1  single-cycle pulse when a requested value becomes the displayed value.
- o_site_sel  out  2  digit index driven to the 4:1 digit mux (0 = ones … 3 = thousands).
- o_digit  out  4  shadow digit selected by o_site_sel.
- o_fnd_com  out  4  active-low common enables, one-hot-low; bit n is digit n.
- o_frame_tick  out  1  pulse on the last cycle of slot 3.

Function
REQ-005 SHALL run a slot counter 0..P_SLOT_CYC-1 that wraps to 0.
- Each wrap advances o_site_sel 0→1→2→3→0.
REQ-006 SHALL implement a two-state FSM per slot:
- ST_BLANK: counter < P_BLANK_CYC; o_fnd_com = 4'b1111.
- ST_ON: remaining cycles of the slot; o_fnd_com drives bit o_site_sel low.
REQ-007 SHALL change o_site_sel only on the cycle the counter wraps, so the select never changes while a digit is lit.
REQ-008 SHALL register o_digit as shadow[o_site_sel], valid in the same cycle as o_site_sel.
REQ-009 SHALL latch i_bcd into a pending register on any cycle i_load=1.
- If several loads occur before a frame boundary, the last one wins and only one ack is produced.
REQ-010 SHALL copy pending into the shadow register only at a frame boundary (slot-3 wrap) and pulse o_load_ack for 1 cycle in the following cycle.
REQ-011 SHALL, when i_load=1 in the frame-boundary cycle itself, bypass pending and load i_bcd into the shadow at that boundary.
REQ-012 SHALL NOT modify the shadow or pulse o_load_ack at a boundary with no load pending.
REQ-013 SHALL pass non-BCD digit values (A–F) through to o_digit unchanged.
REQ-014 SHALL assert o_frame_tick every 4*P_SLOT_CYC cycles, in the slot-3 wrap cycle.

Reset
REQ-015 SHALL, while i_reset_n=0 at a clock edge, set:
- counter=0, state=ST_BLANK, o_site_sel=0.
- o_fnd_com=4'b1111, o_digit=0, shadow=0.
- pending flag=0, o_load_ack=0, o_frame_tick=0.
REQ-016 SHALL, when reset occurs mid-slot or mid-load, discard any pending value with no ack; scanning restarts at slot 0 in ST_BLANK.

Configuration
REQ-017 SHALL implement leading-zero blanking when FND_LEADING_ZERO_BLANK_EN is defined:
- In ST_ON, digit n (n=3..1) stays dark (com bit high) if shadow digit n and every more-significant digit are 0.
- Digit 0 is always lit.
REQ-018 SHALL light every digit in ST_ON when FND_LEADING_ZERO_BLANK_EN is undefined.

Structure
REQ-019 SHALL take the following from shared package fnd_pkg:
- The FSM state enum (ST_BLANK, ST_ON).
- FND_DIGITS=4.
- FND_COM_OFF=4'b1111.
- The BCD digit typedef (4-bit).
REQ-020 SHALL implement the slot counter and blank/on phase decode in one sub-module, fnd_slot_timer, which outputs slot_wrap and phase_on.

Verification (P_SLOT_CYC=8, P_BLANK_CYC=2)
REQ-021 SHALL cover reset release:
- o_fnd_com=1111 for 2 cycles, then 1110 for 6 cycles, then 1111 for 2 cycles, then 1101.
- o_frame_tick after exactly 32 cycles.
REQ-022 SHALL cover load mid-frame:
- i_load with 16'h1234 at cycle 5 → o_digit unchanged until the cycle-32 boundary.
- Then one o_load_ack pulse, and digits read 4,3,2,1 in slots 0..3.
REQ-023 SHALL cover loads 16'h1111 then 16'h5678 in the same frame → a single ack, and the shadow holds 16'h5678.
REQ-024 SHALL cover i_load with 16'h0042 exactly in the boundary cycle → applied at that boundary, ack on the next cycle.
- With the macro defined, o_fnd_com stays 1111 during ST_ON of slots 2 and 3.
- Without the macro, it is 1011 and 0111 respectively.
REQ-025 SHALL cover i_reset_n=0 for 1 cycle during slot 2 with a load pending → all outputs return to reset values, no ack follows, and scanning restarts at slot 0.

Source files
------------

// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg -- shared types and constants for the 4-digit FND scan controller.
//   fnd_state_e : per-slot phase (ST_BLANK dead time, ST_ON digit lit)
//   FND_DIGITS  : number of multiplexed digits
//   FND_COM_OFF : all common enables inactive (active-low)
//   bcd_digit_t : one 4-bit digit (non-BCD codes A-F are carried unchanged)
// Helper functions pick a digit out of a packed 16-bit value and decide
// whether a digit is a leading zero (used only when
// FND_LEADING_ZERO_BLANK_EN is defined).
// -----------------------------------------------------------------------------
package fnd_pkg;

    localparam int         FND_DIGITS  = 4;
    localparam logic [3:0] FND_COM_OFF = 4'b1111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } fnd_state_e;

    typedef logic [3:0] bcd_digit_t;

    // Select digit idx (0 = ones ... 3 = thousands) from a packed value.
    function automatic bcd_digit_t get_digit(input logic [15:0] value, input logic [1:0] idx);
        bcd_digit_t d;
        case (idx)
            2'd0:    d = value[3:0];
            2'd1:    d = value[7:4];
            2'd2:    d = value[11:8];
            2'd3:    d = value[15:12];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    // A digit is a leading zero when it and every more-significant digit
    // are zero. The ones digit never counts as a leading zero.
    function automatic logic lz_dark(input logic [15:0] value, input logic [1:0] idx);
        logic dark;
        case (idx)
            2'd0:    dark = 1'b0;
            2'd1:    dark = (value[15:4] == 12'h000);
            2'd2:    dark = (value[15:8] == 8'h00);
            2'd3:    dark = (value[15:12] == 4'h0);
            default: dark = 1'b0;
        endcase
        return dark;
    endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// -----------------------------------------------------------------------------
// fnd_slot_timer -- slot counter 0..P_SLOT_CYC-1 plus blank/on phase FSM.
// Ports:
//   clk_i           rising-edge clock
//   rst_n_i         synchronous active-low reset (counter 0, ST_BLANK)
//   slot_wrap_o     current cycle is the last cycle of the slot
//   slot_wrap_nxt_o the coming cycle will be the last cycle of the slot
//   phase_on_o      the coming cycle is in ST_ON
// The "coming cycle" outputs let the parent register its drive signals so
// they line up exactly with the counter value they belong to.
// -----------------------------------------------------------------------------
module fnd_slot_timer
    import fnd_pkg::*;
#(
    parameter int P_SLOT_CYC  = 100000,
    parameter int P_BLANK_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic slot_wrap_o,
    output logic slot_wrap_nxt_o,
    output logic phase_on_o
);

    localparam int CNT_W = (P_SLOT_CYC > 2) ? $clog2(P_SLOT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(P_SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(P_BLANK_CYC);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    fnd_state_e       state_q, state_d;

    // Next counter value and next phase; the phase flips when the next
    // counter value crosses the dead-time boundary or wraps to zero.
    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        case (state_q)
            ST_BLANK: state_d = (cnt_d == CNT_BLANK) ? ST_ON : ST_BLANK;
            ST_ON:    state_d = (cnt_d == CNT_ZERO) ? ST_BLANK : ST_ON;
            default:  state_d = ST_BLANK;
        endcase
    end

    // Counter and phase state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q   <= CNT_ZERO;
            state_q <= ST_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign slot_wrap_o     = (cnt_q == CNT_LAST);
    assign slot_wrap_nxt_o = (cnt_d == CNT_LAST);
    assign phase_on_o      = (state_d == ST_ON);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_scan_ctrl -- 4-digit multiplexed FND scan controller with
// frame-synchronous double-buffered display value.
// Ports:
//   i_clk        rising-edge clock
//   i_reset_n    synchronous active-low reset
//   i_bcd[15:0]  four digits, [15:12] thousands ... [3:0] ones
//   i_load       strobe: display i_bcd from the next frame boundary
//   o_load_ack   1-cycle pulse when a requested value becomes displayed
//   o_site_sel   digit index driven to the digit mux (0 = ones)
//   o_digit      shadow digit selected by o_site_sel
//   o_fnd_com    active-low one-hot common enables (1111 = all dark)
//   o_frame_tick pulse on the last cycle of slot 3
// Optional feature macro: FND_LEADING_ZERO_BLANK_EN -- keeps leading-zero
// digits dark; default build lights every digit.
// All outputs are registered and computed from next-state values so they
// are valid in the same cycle as the slot counter they belong to.
// -----------------------------------------------------------------------------
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int P_SLOT_CYC  = 100000,
    parameter int P_BLANK_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_bcd,
    input  logic        i_load,
    output logic        o_load_ack,
    output logic [1:0]  o_site_sel,
    output logic [3:0]  o_digit,
    output logic [3:0]  o_fnd_com,
    output logic        o_frame_tick
);

    logic slot_wrap_s, slot_wrap_nxt_s, phase_on_s;

    fnd_slot_timer #(
        .P_SLOT_CYC  (P_SLOT_CYC),
        .P_BLANK_CYC (P_BLANK_CYC)
    ) u_slot_timer (
        .clk_i           (i_clk),
        .rst_n_i         (i_reset_n),
        .slot_wrap_o     (slot_wrap_s),
        .slot_wrap_nxt_o (slot_wrap_nxt_s),
        .phase_on_o      (phase_on_s)
    );

    logic [1:0]  sel_q, sel_d;
    logic [3:0]  digit_q, digit_d;
    logic [3:0]  com_q, com_d;
    logic        ack_q, ack_d;
    logic        tick_q, tick_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        frame_bnd_s;

    // Frame boundary is the wrap cycle of slot 3.
    assign frame_bnd_s = slot_wrap_s && (sel_q == 2'd3);

    // Next-state: digit select, load buffering and registered drive values.
    always_comb begin
        sel_d      = slot_wrap_s ? (sel_q + 2'd1) : sel_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;

        if (frame_bnd_s) begin
            // A load in the boundary cycle itself wins over the pending value.
            if (i_load) begin
                shadow_d = i_bcd;
                ack_d    = 1'b1;
            end else if (pend_vld_q) begin
                shadow_d = pend_q;
                ack_d    = 1'b1;
            end else begin
                ack_d    = 1'b0;
            end
            pend_vld_d = 1'b0;
        end else if (i_load) begin
            pend_d     = i_bcd;
            pend_vld_d = 1'b1;
        end else begin
            pend_vld_d = pend_vld_q;
        end

        digit_d = get_digit(shadow_d, sel_d);
        tick_d  = slot_wrap_nxt_s && (sel_d == 2'd3);

        com_d = FND_COM_OFF;
        if (phase_on_s) begin
`ifdef FND_LEADING_ZERO_BLANK_EN
            if (!lz_dark(shadow_d, sel_d)) begin
                com_d = ~(4'b0001 << sel_d);
            end else begin
                com_d = FND_COM_OFF;
            end
`else
            com_d = ~(4'b0001 << sel_d);
`endif
        end else begin
            com_d = FND_COM_OFF;
        end
    end

    // Output and buffer registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sel_q      <= 2'd0;
            digit_q    <= 4'd0;
            com_q      <= FND_COM_OFF;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
            shadow_q   <= 16'h0000;
            pend_q     <= 16'h0000;
            pend_vld_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            digit_q    <= digit_d;
            com_q      <= com_d;
            ack_q      <= ack_d;
            tick_q     <= tick_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign o_site_sel   = sel_q;
    assign o_digit      = digit_q;
    assign o_fnd_com    = com_q;
    assign o_load_ack   = ack_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_ctrl -- directed bench for fnd_scan_ctrl with 8-cycle slots and
// 2 cycles of dead time. Cycle 0 is the first cycle after reset release;
// outputs are sampled on the falling edge, inputs driven between edges.
// -----------------------------------------------------------------------------
module tb_fnd_scan_ctrl;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] bcd;
    logic        load;
    logic        load_ack;
    logic [1:0]  site_sel;
    logic [3:0]  digit;
    logic [3:0]  fnd_com;
    logic        frame_tick;

    int compared   = 0;
    int mismatched = 0;
    int c;                    // cycle index since reset release
    logic [15:0] cur_shadow;  // value expected on display
    logic [15:0] nxt_shadow;  // value expected after the next swap
    int swap_at;              // cycle at which nxt_shadow appears with ack

    always #5 clk = ~clk;

    fnd_scan_ctrl #(
        .P_SLOT_CYC  (SLOT),
        .P_BLANK_CYC (BLANK)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_bcd        (bcd),
        .i_load       (load),
        .o_load_ack   (load_ack),
        .o_site_sel   (site_sel),
        .o_digit      (digit),
        .o_fnd_com    (fnd_com),
        .o_frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_com(input int cc, input logic [15:0] sh);
        int         sel;
        logic [3:0] m;
        sel = (cc / SLOT) % 4;
        if ((cc % SLOT) < BLANK) return 4'hF;
`ifdef FND_LEADING_ZERO_BLANK_EN
        if ((sel > 0) && ((sh >> (4 * sel)) == 16'h0000)) return 4'hF;
`endif
        m = 4'b0001 << sel;
        return ~m;
    endfunction

    task automatic check_cycle();
        int         sel;
        logic [3:0] d;
        if (c == swap_at) cur_shadow = nxt_shadow;
        sel = (c / SLOT) % 4;
        d   = 4'(cur_shadow >> (4 * sel));
        chk("site_sel",   16'(site_sel),   16'(sel));
        chk("fnd_com",    16'(fnd_com),    16'(exp_com(c, cur_shadow)));
        chk("digit",      16'(digit),      16'(d));
        chk("load_ack",   16'(load_ack),   16'(c == swap_at));
        chk("frame_tick", 16'(frame_tick), 16'((c % 32) == 31));
    endtask

    task automatic check_reset_outputs();
        chk("rst_site_sel",   16'(site_sel),   16'h0000);
        chk("rst_fnd_com",    16'(fnd_com),    16'h000F);
        chk("rst_digit",      16'(digit),      16'h0000);
        chk("rst_load_ack",   16'(load_ack),   16'h0000);
        chk("rst_frame_tick", 16'(frame_tick), 16'h0000);
    endtask

    // Check the current cycle, advance one clock; load strobes last one cycle.
    task automatic step();
        check_cycle();
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        c++;
    endtask

    task automatic run_to(input int target);
        while (c < target) step();
    endtask

    initial begin
        reset_n    = 1'b0;
        load       = 1'b0;
        bcd        = 16'h0000;
        c          = 0;
        cur_shadow = 16'h0000;
        nxt_shadow = 16'h0000;
        swap_at    = -1;

        // Reset state, then release: slot pattern and frame tick timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;

        // Load mid-frame: held back until the cycle-31 boundary.
        run_to(5);
        load = 1'b1; bcd = 16'h1234;
        nxt_shadow = 16'h1234; swap_at = 32;

        // Two loads in one frame: last wins, single ack.
        run_to(40);
        load = 1'b1; bcd = 16'h1111;
        run_to(45);
        load = 1'b1; bcd = 16'h5678;
        nxt_shadow = 16'h5678; swap_at = 64;

        // Frame 64..95 has no load: no ack at 96, shadow kept.
        // Load exactly in the boundary cycle 127.
        run_to(127);
        load = 1'b1; bcd = 16'h0042;
        nxt_shadow = 16'h0042; swap_at = 128;

        // Non-BCD codes pass straight through.
        run_to(140);
        load = 1'b1; bcd = 16'hF0A9;
        nxt_shadow = 16'hF0A9; swap_at = 160;

        // Pending load, then a one-cycle reset during slot 2.
        run_to(195);
        load = 1'b1; bcd = 16'h7777;
        run_to(210);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset_n    = 1'b1;
        c          = 0;
        cur_shadow = 16'h0000;
        swap_at    = -1;
        run_to(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
